// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter/rotator (ROL, ROR, SHL, SAR) with one register stage per amount bit.
// Optional feature: define BARREL_SHIFT_CARRY_EN to add the out_carry sideband (last bit shifted out).
module barrel_shift_pipe #(
  parameter  int WIDTH = 16,
  parameter  int TAG_W = 4,
  localparam int LOG2W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LOG2W-1:0] in_amt,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
`ifdef BARREL_SHIFT_CARRY_EN
  ,
  output logic             out_carry
`endif
);

  localparam logic [1:0] MODE_ROL = 2'b00;
  localparam logic [1:0] MODE_ROR = 2'b01;
  localparam logic [1:0] MODE_SHL = 2'b10;

  logic advance;

  // Per-stage inputs (*_d, src_*) and registered state (*_q); stage k holds the result of shifts 2^0..2^k.
  logic [WIDTH-1:0] src_data [LOG2W];
  logic [WIDTH-1:0] data_d   [LOG2W];
  logic [LOG2W-1:0] amt_d    [LOG2W];
  logic [1:0]       mode_d   [LOG2W];
  logic [TAG_W-1:0] tag_d    [LOG2W];
  logic             valid_d  [LOG2W];

  logic [WIDTH-1:0] data_q   [LOG2W];
  logic [LOG2W-1:0] amt_q    [LOG2W];
  logic [1:0]       mode_q   [LOG2W];
  logic [TAG_W-1:0] tag_q    [LOG2W];
  logic             valid_q  [LOG2W];

`ifdef BARREL_SHIFT_CARRY_EN
  logic             src_carry [LOG2W];
  logic             carry_d   [LOG2W];
  logic             carry_q   [LOG2W];
`endif

  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] x,
                                                input logic [1:0]       mode,
                                                input int               sh);
    case (mode)
      MODE_ROL: shift_by = (x << sh) | (x >> (WIDTH - sh));
      MODE_ROR: shift_by = (x >> sh) | (x << (WIDTH - sh));
      MODE_SHL: shift_by = x << sh;
      default:  shift_by = WIDTH'($signed(x) >>> sh);
    endcase
  endfunction

  // A global stall: the whole pipe moves together or holds together.
  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;

  for (genvar gi = 0; gi < LOG2W; gi++) begin : g_stage
    localparam int SH = 1 << gi;

    if (gi == 0) begin : g_head
      assign src_data[gi] = in_data;
      assign amt_d[gi]    = in_amt;
      assign mode_d[gi]   = in_mode;
      assign tag_d[gi]    = in_tag;
      assign valid_d[gi]  = in_valid & advance;
`ifdef BARREL_SHIFT_CARRY_EN
      assign src_carry[gi] = 1'b0;
`endif
    end else begin : g_link
      assign src_data[gi] = data_q[gi-1];
      assign amt_d[gi]    = amt_q[gi-1];
      assign mode_d[gi]   = mode_q[gi-1];
      assign tag_d[gi]    = tag_q[gi-1];
      assign valid_d[gi]  = valid_q[gi-1];
`ifdef BARREL_SHIFT_CARRY_EN
      assign src_carry[gi] = carry_q[gi-1];
`endif
    end

    assign data_d[gi] = amt_d[gi][gi] ? shift_by(src_data[gi], mode_d[gi], SH) : src_data[gi];

`ifdef BARREL_SHIFT_CARRY_EN
    // The highest active stage produces the final carry: its last bit out equals A[n-1] / A[WIDTH-n].
    assign carry_d[gi] = !amt_d[gi][gi] ? src_carry[gi] :
                         mode_d[gi][0]  ? src_data[gi][SH-1] : src_data[gi][WIDTH-SH];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LOG2W; k++) begin
        data_q[k]  <= '0;
        amt_q[k]   <= '0;
        mode_q[k]  <= '0;
        tag_q[k]   <= '0;
        valid_q[k] <= 1'b0;
`ifdef BARREL_SHIFT_CARRY_EN
        carry_q[k] <= 1'b0;
`endif
      end
    end else if (advance) begin
      for (int k = 0; k < LOG2W; k++) begin
        data_q[k]  <= data_d[k];
        amt_q[k]   <= amt_d[k];
        mode_q[k]  <= mode_d[k];
        tag_q[k]   <= tag_d[k];
        valid_q[k] <= valid_d[k];
`ifdef BARREL_SHIFT_CARRY_EN
        carry_q[k] <= carry_d[k];
`endif
      end
    end
  end

  assign out_valid = valid_q[LOG2W-1];
  assign out_data  = data_q[LOG2W-1];
  assign out_tag   = tag_q[LOG2W-1];
`ifdef BARREL_SHIFT_CARRY_EN
  assign out_carry = carry_q[LOG2W-1];
`endif

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Scoreboard bench for barrel_shift_pipe (WIDTH=16): driver pushes expected results, negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_barrel_shift_pipe;
  localparam int W   = 16;
  localparam int AW  = 4;
  localparam int TW  = 4;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [AW-1:0] in_amt = '0;
  logic [1:0]    in_mode = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic [TW-1:0] out_tag;
`ifdef BARREL_SHIFT_CARRY_EN
  logic          out_carry;
`endif

  barrel_shift_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag)
`ifdef BARREL_SHIFT_CARRY_EN
    , .out_carry(out_carry)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0]  d;
    logic [TW-1:0] tag;
    logic          c;
    int            acc;
    bit            lat;
  } exp_t;
  exp_t q[$];

  int n_tests = 0;
  int n_fail  = 0;
  bit rnd_rdy = 0;

  always @(posedge clk) if (rnd_rdy) #1 out_ready = ($urandom_range(0, 3) != 0);

  // Reference built directly from the per-bit result definitions.
  function automatic void model(input logic [W-1:0] a, input int n, input logic [1:0] m,
                                output logic [W-1:0] r, output logic c);
    r = '0;
    for (int i = 0; i < W; i++) begin
      case (m)
        2'b00: r[i] = a[AW'((i - n + W) % W)];
        2'b01: r[i] = a[AW'((i + n) % W)];
        2'b10: r[i] = (i >= n) ? a[AW'(i - n)] : 1'b0;
        default: r[i] = (i + n < W) ? a[AW'(i + n)] : a[W-1];
      endcase
    end
    if (n == 0) c = 1'b0;
    else if (m[0]) c = a[AW'(n - 1)];
    else c = a[AW'(W - n)];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic send(input logic [W-1:0] a, input logic [AW-1:0] amt, input logic [1:0] m,
                      input logic [TW-1:0] tag, input logic [W-1:0] er, input logic ec, input bit lat);
    int w;
    exp_t e;
    in_valid = 1'b1; in_data = a; in_amt = amt; in_mode = m; in_tag = tag;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 200) begin @(negedge clk); w++; end
    if (!in_ready) begin
      n_fail++;
      $display("[TB] FAIL accept_timeout: in_ready stuck 0 for tag %0d", tag);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
    @(posedge clk);
    e.d = er; e.tag = tag; e.c = ec; e.acc = cyc; e.lat = lat;
    q.push_back(e);
    #2 in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (q.size() != 0 && w < 2000) begin @(negedge clk); w++; end
    check("drain_outstanding", q.size(), 0);
    @(posedge clk); #2;
  endtask

  // Monitor: compares every emitted result, and checks hold/stall behaviour while backpressured.
  logic         held = 1'b0;
  logic [W-1:0] held_data;
  logic [TW-1:0] held_tag;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (out_valid && held) begin
        check("stall_data_stable", out_data, held_data);
        check("stall_tag_stable", out_tag, held_tag);
      end
      if (out_valid && !out_ready) begin
        check("stall_in_ready", in_ready, 0);
        held = 1'b1; held_data = out_data; held_tag = out_tag;
      end else begin
        held = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_tests++; n_fail++;
          $display("[TB] FAIL unexpected_output: tag %0d data %h with empty scoreboard", out_tag, out_data);
        end else begin
          e = q.pop_front();
          $display("[TB] out tag=%0d data=%h expect=%h", out_tag, out_data, e.d);
          check("result_data", out_data, e.d);
          check("result_tag", out_tag, e.tag);
`ifdef BARREL_SHIFT_CARRY_EN
          check("result_carry", out_carry, e.c);
`endif
          if (e.lat) check("latency", cyc - e.acc, LAT);
        end
      end
    end
  end

  // Directed vectors: mode, A, amt, expected result, expected carry.
  logic [1:0]    v_m [12] = '{2'd0, 2'd1, 2'd1, 2'd3, 2'd2, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [W-1:0]  v_a [12] = '{16'h8001, 16'h0001, 16'h000F, 16'h8004, 16'hFFFF, 16'h1234,
                              16'h7FF0, 16'h1234, 16'hABCD, 16'h0001, 16'h8000, 16'hABCD};
  logic [AW-1:0] v_n [12] = '{4'd1, 4'd4, 4'd4, 4'd3, 4'd0, 4'd4, 4'd4, 4'd15, 4'd15, 4'd15, 4'd15, 4'd0};
  logic [W-1:0]  v_r [12] = '{16'h0003, 16'h1000, 16'hF000, 16'hF000, 16'hFFFF, 16'h2340,
                              16'h07FF, 16'h091A, 16'h579B, 16'h8000, 16'hFFFF, 16'hABCD};
  logic          v_c [12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    logic [W-1:0] a, r;
    logic c;
    int cnt;

    #2 rst_n = 1'b0;
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_tag", out_tag, 0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", in_ready, 1);
    @(posedge clk); #2;

    for (int i = 0; i < 12; i++) send(v_a[i], v_n[i], v_m[i], TW'(i), v_r[i], v_c[i], 1'b1);
    drain();

    fork
      for (int i = 0; i < 8; i++) begin
        a = W'($urandom);
        model(a, i, 2'(i), r, c);
        send(a, AW'(i), 2'(i), TW'(i), r, c, 1'b0);
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    rnd_rdy = 1'b1;
    cnt = 0;
    for (int m = 0; m < 4; m++) begin
      for (int n = 0; n < 16; n++) begin
        for (int k = 0; k < 16; k++) begin
          a = W'($urandom);
          model(a, n, 2'(m), r, c);
          send(a, AW'(n), 2'(m), TW'(cnt), r, c, 1'b0);
          cnt++;
          repeat ($urandom_range(0, 1)) begin @(posedge clk); #2; end
        end
      end
    end
    drain();
    rnd_rdy = 1'b0;

    @(posedge clk); #1 out_ready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      a = W'($urandom) | 16'h0001;
      model(a, 0, 2'd0, r, c);
      send(a, 4'd0, 2'd0, TW'(4 + i), r, c, 1'b0);
    end
    repeat (4) @(posedge clk);
    #3;
    check("inflight_valid", out_valid, 1);
    rst_n = 1'b0;
    q.delete();
    #1;
    check("midreset_out_valid", out_valid, 0);
    check("midreset_out_data", out_data, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #2;
    send(16'h8001, 4'd1, 2'd0, 4'd9, 16'h0003, 1'b1, 1'b1);
    drain();
    repeat (4) @(posedge clk);
    #1 check("idle_after_drain", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
